mem_burst_rd_responder: RTL and testbench
=========================================

# mem_burst_rd_responder

Memory-side responder for the 32-byte-aligned burst read protocol issued by the instruction cache. It accepts one line-fill request at a time, reads eight consecutive 32-bit words from an internal synchronous-read backing RAM, and returns them as an 8-beat burst with `last` on beat 7. It sits between the I-Cache memory port and simulation or FPGA block RAM. A word-write init port preloads program images.

## Interface
- `ADDR_WIDTH`, default 10: word-address width of the backing RAM, giving 2^ADDR_WIDTH words (4 KB at the default).
- `RSP_LAT`, default 4: extra cycles before beat 0. Only meaningful with `MEM_RSP_LAT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `from_cache_rd_req_valid` in 1: a read request is pending.
- `from_cache_rd_req_addr` in 32: request byte address. Bits [4:0] are ignored.
- `to_cache_rd_req_ready` out 1: the block can accept a request.
- `to_cache_rd_rsp_valid` out 1: the current beat is valid.
- `to_cache_rd_rsp_data` out 32: beat data.
- `to_cache_rd_rsp_last` out 1: the current beat is beat 7.
- `from_cache_rd_rsp_ready` in 1: the cache accepts the current beat.
- `init_wen` in 1: word write enable.
- `init_addr` in ADDR_WIDTH: write word address.
- `init_wdata` in 32: write data.

## Operation
- **States:**
  - IDLE: `req_ready`=1.
  - WAIT: latency counter runs. Present only with the macro.
  - FIRST: RAM read of beat 0 is issued.
  - BURST: `rsp_valid`=1.
- **Request handshake:** a request is accepted on a cycle where `req_valid` && `req_ready`.
  - The base word address is latched as `req_addr[ADDR_WIDTH+1:5]` concatenated with 3'b000. Address bits above the RAM range are ignored, so the address wraps modulo the RAM size.
  - The beat index `beat_idx` (3 bits) is cleared to 0.
- **Transitions:**
  - IDLE → FIRST on handshake, or IDLE → WAIT when the macro is defined.
  - WAIT → FIRST when the counter reaches `RSP_LAT`-1.
  - FIRST → BURST unconditionally.
- **BURST behaviour:**
  - Beat k carries `RAM[base+k]`; k runs 0..7 in ascending order.
  - On `rsp_valid` && `rsp_ready`, if `beat_idx`==7, go to IDLE.
  - Otherwise increment `beat_idx` and issue a RAM read of `base+beat_idx+1` in the same cycle.
- **Back-pressure:** while `rsp_valid` && !`rsp_ready`, `rsp_data` and `rsp_last` hold stable. The RAM read enable is deasserted and the RAM output register holds.
- `rsp_last` = (state==BURST) && (`beat_idx`==7).
- **Init writes:** an init write is performed only in IDLE. `init_wen` in any other state is ignored.
  - If an init write and a request handshake occur in the same IDLE cycle, the write completes first. A subsequent burst covering that word returns the new data.
- **Request address stability:** `req_addr` and `req_valid` changes outside IDLE have no effect. There is no queueing.
- **Reset:** when `rst`==0 at an edge, the state goes to IDLE, `beat_idx`=0, and the latency counter=0.
  - After that edge: `req_ready`=0 while `rst` is low, `rsp_valid`=0, `rsp_last`=0, `rsp_data`=0.
  - Reset mid-burst abandons the burst without asserting `last`.
  - RAM contents are preserved.

## Timing
- **First-beat latency:** handshake at edge T; FIRST during cycle T..T+1; beat 0 valid after edge T+1. Total: 2 cycles from handshake to beat 0, plus `RSP_LAT` with the macro.
- **Throughput:** one beat per cycle while `rsp_ready` is held high, so 8 beats in 8 consecutive cycles.
- **Request rate:** `req_ready` returns the cycle after the beat-7 handshake. Minimum request-to-request spacing is 10 cycles without the macro.
- **RAM timing:** synchronous read with read enable, one-cycle latency, output register. The write port is synchronous.

## Configuration
- `MEM_RSP_LAT_EN` defined: the WAIT state and a 5-bit latency counter are compiled in, adding exactly `RSP_LAT` idle cycles (`rsp_valid`=0) before FIRST. `RSP_LAT`=0 behaves as undefined.
- `MEM_RSP_LAT_EN` undefined: no WAIT state or counter; the `RSP_LAT` parameter is unused.

## Structure
- **Shared package `mem_burst_pkg`:**
  - `BURST_BEATS`=8, `BEAT_IDX_WIDTH`=3, `LINE_OFFSET_WIDTH`=5.
  - State localparams: one-hot, 4 bits, with the WAIT code reserved.
- **Sub-module `burst_ram`:** parameterized by ADDR_WIDTH and data width 32.
  - One synchronous write port, one synchronous read port with `rd_en`.
  - The output register holds when `rd_en`=0 and resets to 0.
- **Top level:** the FSM, `beat_idx`, base register, and latency counter live in the top.

## Test plan
- **Single burst:**
  - Stimulus: preload words 8..15 with 0x100..0x107; request addr 0x0000_0020; `rsp_ready`=1.
  - Required: beats 0x100..0x107 on 8 consecutive cycles; `last` only on 0x107; beat 0 two cycles after the handshake.
- **Unaligned address:** request 0x0000_003C → the same 0x100..0x107 burst; low bits ignored.
- **Back-pressure:**
  - Stimulus: toggle `rsp_ready` 1,0,0,1,...
  - Required: data holds during ready=0; no beat is lost or duplicated; `last` appears exactly once.
- **Wrap-around:** request byte addr 0x0000_1FE0 with ADDR_WIDTH=10 → reads words 0x3F8..0x3FF, identical to a request at 0x0000_0FE0.
- **Init/request collision:** in the same IDLE cycle, write word 8=0xDEAD_BEEF and request 0x20 → beat 0 = 0xDEAD_BEEF.
- **Reset mid-burst:**
  - Stimulus: assert `rst`=0 after beat 3.
  - Required: next cycle `rsp_valid`=0, `rsp_last`=0, `rsp_data`=0.
  - After release: `req_ready`=1, and a new request returns correct data.
  - With `MEM_RSP_LAT_EN` and `RSP_LAT`=4: beat 0 appears 6 cycles after the handshake.

Source files
------------

// File: rtl/mem_burst_rd_responder_pkg.sv
// Shared constants and state encoding for the burst read responder.
package mem_burst_pkg;

  localparam int unsigned BURST_BEATS       = 8;
  localparam int unsigned BEAT_IDX_WIDTH    = 3;
  localparam int unsigned LINE_OFFSET_WIDTH = 5;

  localparam logic [BEAT_IDX_WIDTH-1:0] LAST_BEAT = BEAT_IDX_WIDTH'(BURST_BEATS - 1);

  // One-hot; the WAIT code stays reserved even when the latency stage is not built.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_WAIT  = 4'b0010,
    ST_FIRST = 4'b0100,
    ST_BURST = 4'b1000
  } state_t;

endpackage

// File: rtl/mem_burst_rd_responder_burst_ram.sv
// Backing RAM: one synchronous write port, one synchronous read port with
// read enable and a resettable output register that holds when not reading.
module burst_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port output register: cleared by reset, holds while rd_en is low.
  always_ff @(posedge clk) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mem_burst_rd_responder.sv
// Burst read responder: accepts one 32-byte line request at a time and
// returns eight words from the backing RAM as an 8-beat burst.
// Optional feature macro: MEM_RSP_LAT_EN adds a WAIT state of RSP_LAT cycles
// before the first RAM read.
module mem_burst_rd_responder
  import mem_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RSP_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  from_cache_rd_req_valid,
  input  logic [31:0]           from_cache_rd_req_addr,
  output logic                  to_cache_rd_req_ready,
  output logic                  to_cache_rd_rsp_valid,
  output logic [31:0]           to_cache_rd_rsp_data,
  output logic                  to_cache_rd_rsp_last,
  input  logic                  from_cache_rd_rsp_ready,
  input  logic                  init_wen,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [31:0]           init_wdata
);

  localparam int unsigned LINE_WIDTH = ADDR_WIDTH - BEAT_IDX_WIDTH;

  state_t                    state;
  state_t                    state_next;
  logic [BEAT_IDX_WIDTH-1:0] beat_idx;
  logic [BEAT_IDX_WIDTH-1:0] beat_nxt;
  logic [LINE_WIDTH-1:0]     line_base;
  logic                      req_fire;
  logic                      beat_fire;
  logic                      ram_we;
  logic                      ram_rd_en;
  logic [ADDR_WIDTH-1:0]     ram_rd_addr;
  logic                      unused_bits;

  assign req_fire  = from_cache_rd_req_valid && to_cache_rd_req_ready;
  assign beat_fire = to_cache_rd_rsp_valid && from_cache_rd_rsp_ready;
  assign beat_nxt  = beat_idx + BEAT_IDX_WIDTH'(1);

`ifdef MEM_RSP_LAT_EN
  localparam int unsigned LAT_CNT_WIDTH = 5;

  logic [LAT_CNT_WIDTH-1:0] lat_cnt;
  logic                     lat_done;

  assign lat_done = (lat_cnt == LAT_CNT_WIDTH'(RSP_LAT - 1));

  // Latency counter runs only while in WAIT and is zero everywhere else.
  always_ff @(posedge clk) begin
    if (!rst || state != ST_WAIT) lat_cnt <= '0;
    else                          lat_cnt <= lat_cnt + LAT_CNT_WIDTH'(1);
  end

  assign unused_bits = ^{from_cache_rd_req_addr[31:ADDR_WIDTH+2],
                         from_cache_rd_req_addr[LINE_OFFSET_WIDTH-1:0]};
`else
  assign unused_bits = ^{from_cache_rd_req_addr[31:ADDR_WIDTH+2],
                         from_cache_rd_req_addr[LINE_OFFSET_WIDTH-1:0],
                         (RSP_LAT != 0)};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_fire) begin
`ifdef MEM_RSP_LAT_EN
          state_next = (RSP_LAT != 0) ? ST_WAIT : ST_FIRST;
`else
          state_next = ST_FIRST;
`endif
        end
      end
`ifdef MEM_RSP_LAT_EN
      ST_WAIT:  if (lat_done) state_next = ST_FIRST;
`endif
      ST_FIRST: state_next = ST_BURST;
      ST_BURST: if (beat_fire && beat_idx == LAST_BEAT) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs and RAM control decoded from state.
  always_comb begin
    to_cache_rd_req_ready = 1'b0;
    to_cache_rd_rsp_valid = 1'b0;
    to_cache_rd_rsp_last  = 1'b0;
    ram_we                = 1'b0;
    ram_rd_en             = 1'b0;
    ram_rd_addr           = {line_base, beat_nxt};
    case (state)
      ST_IDLE: begin
        to_cache_rd_req_ready = rst;
        ram_we                = init_wen && rst;
      end
      ST_FIRST: begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = {line_base, {BEAT_IDX_WIDTH{1'b0}}};
      end
      ST_BURST: begin
        to_cache_rd_rsp_valid = 1'b1;
        to_cache_rd_rsp_last  = (beat_idx == LAST_BEAT);
        // Prefetch the next beat only when the current one is taken, so the
        // RAM output register doubles as the back-pressure holding register.
        ram_rd_en             = from_cache_rd_rsp_ready && (beat_idx != LAST_BEAT);
      end
      default: ;
    endcase
  end

  // Line base and beat index tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_idx  <= '0;
      line_base <= '0;
    end else if (req_fire) begin
      beat_idx  <= '0;
      line_base <= from_cache_rd_req_addr[ADDR_WIDTH+1:LINE_OFFSET_WIDTH];
    end else if (beat_fire && beat_idx != LAST_BEAT) begin
      beat_idx  <= beat_nxt;
    end
  end

  burst_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (32)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we),
    .wr_addr (init_addr),
    .wr_data (init_wdata),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (to_cache_rd_rsp_data)
  );

endmodule

// File: tb/tb_mem_burst_rd_responder.sv
// Scoreboard bench for mem_burst_rd_responder with a word-array memory model.
module tb_mem_burst_rd_responder;

  localparam int unsigned AW    = 10;
  localparam int unsigned WORDS = 1 << AW;
  localparam int unsigned LAT   = 4;
`ifdef MEM_RSP_LAT_EN
  localparam int unsigned EXP_LAT = 2 + LAT;
`else
  localparam int unsigned EXP_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic [31:0]   req_addr = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_last;
  logic          rsp_ready = 1'b0;
  logic          init_wen = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [31:0]   init_wdata = '0;

  mem_burst_rd_responder #(
    .ADDR_WIDTH (AW),
    .RSP_LAT    (LAT)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .from_cache_rd_req_valid (req_valid),
    .from_cache_rd_req_addr  (req_addr),
    .to_cache_rd_req_ready   (req_ready),
    .to_cache_rd_rsp_valid   (rsp_valid),
    .to_cache_rd_rsp_data    (rsp_data),
    .to_cache_rd_rsp_last    (rsp_last),
    .from_cache_rd_rsp_ready (rsp_ready),
    .init_wen                (init_wen),
    .init_addr               (init_addr),
    .init_wdata              (init_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic [31:0] model_mem [WORDS];
  beat_t       sbq [$];
  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned cyc = 0;
  int unsigned hs_cyc = 0;
  int unsigned b0_cyc = 0;
  int unsigned acc = 0;
  int unsigned pat = 0;
  int          rdy_mode = 0;
  logic        first_pend = 1'b0;
  logic        full_rdy = 1'b0;
  logic        rr_chk = 1'b0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  logic        hold_l = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random, other = off.
  always @(posedge clk) begin
    #1;
    pat++;
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = (pat % 3 == 0);
      2:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: compares every presented beat against the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (rr_chk) begin
      chk("req_ready_after_last", 32'(req_ready), 32'd1);
      rr_chk = 1'b0;
    end
    if (rsp_valid) begin
      if (first_pend) begin
        chk("first_beat_latency", cyc - hs_cyc, EXP_LAT);
        first_pend = 1'b0;
        b0_cyc = cyc;
      end
      if (hold_v) begin
        chk("hold_data", rsp_data, hold_d);
        chk("hold_last", 32'(rsp_last), 32'(hold_l));
      end
      if (rsp_ready) begin
        hold_v = 1'b0;
        acc++;
        if (sbq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got 0x%08h expected no beat", rsp_data);
        end else begin
          e = sbq.pop_front();
          chk("beat_data", rsp_data, e.d);
          chk("beat_last", 32'(rsp_last), 32'(e.l));
          if (e.l) begin
            rr_chk = 1'b1;
            if (full_rdy) chk("burst_span", cyc - b0_cyc, 32'd7);
          end
        end
      end else begin
        hold_v = 1'b1;
        hold_d = rsp_data;
        hold_l = rsp_last;
      end
    end else begin
      hold_v = 1'b0;
      chk("idle_last", 32'(rsp_last), 32'd0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      compared++;
      mismatched++;
      $display("FAIL idle_timeout: got req_ready=0 expected 1 within 300 cycles");
    end
  endtask

  task automatic mem_write(input int unsigned wa, input logic [31:0] wd);
    wait_idle();
    init_wen = 1'b1; init_addr = AW'(wa); init_wdata = wd;
    model_mem[wa % WORDS] = wd;
    @(posedge clk); #1;
    init_wen = 1'b0;
  endtask

  task automatic burst(input logic [31:0] a, input int mode, input logic do_wr,
                       input int unsigned wa, input logic [31:0] wd, input logic junk);
    int unsigned base;
    beat_t e;
    wait_idle();
    rdy_mode = mode;
    full_rdy = (mode == 0);
    if (do_wr) begin
      init_wen = 1'b1; init_addr = AW'(wa); init_wdata = wd;
      model_mem[wa % WORDS] = wd;
    end
    req_valid = 1'b1;
    req_addr  = a;
    base = ((a / 4) % WORDS) / 8 * 8;
    for (int k = 0; k < 8; k++) begin
      e.d = model_mem[base + k];
      e.l = (k == 7);
      sbq.push_back(e);
    end
    hs_cyc = cyc;
    first_pend = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    init_wen  = 1'b0;
    // Writes and requests while busy must have no effect.
    if (junk) begin
      for (int j = 0; j < 3; j++) begin
        init_wen = 1'b1; init_addr = AW'($urandom); init_wdata = $urandom;
        req_valid = 1'b1; req_addr = $urandom;
        @(posedge clk); #1;
      end
      init_wen  = 1'b0;
      req_valid = 1'b0;
    end
  endtask

  initial begin
    int unsigned s;
    int n;
    logic [31:0] a;
    int unsigned wa;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_last", 32'(rsp_last), 32'd0);
    chk("reset_data", rsp_data, 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("release_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < int'(WORDS); i++) mem_write(i, $urandom);
    for (int i = 0; i < 8; i++) mem_write(8 + i, 32'h100 + i);

    burst(32'h0000_0020, 0, 1'b0, 0, '0, 1'b0);
    burst(32'h0000_003C, 0, 1'b0, 0, '0, 1'b0);
    burst(32'h0000_0020, 1, 1'b0, 0, '0, 1'b0);
    burst(32'h0000_1FE0, 0, 1'b0, 0, '0, 1'b0);
    burst(32'h0000_0FE0, 0, 1'b0, 0, '0, 1'b0);
    burst(32'h0000_0020, 0, 1'b1, 8, 32'hDEAD_BEEF, 1'b0);

    // Reset after beat 3 has been accepted.
    burst(32'h0000_0100, 0, 1'b0, 0, '0, 1'b0);
    s = acc;
    n = 0;
    while (acc != s + 4 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (acc != s + 4) begin
      compared++;
      mismatched++;
      $display("FAIL beat3_timeout: got %0d beats expected 4", acc - s);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("midburst_reset_valid", 32'(rsp_valid), 32'd0);
    chk("midburst_reset_last", 32'(rsp_last), 32'd0);
    chk("midburst_reset_data", rsp_data, 32'd0);
    chk("midburst_reset_req_ready", 32'(req_ready), 32'd0);
    sbq.delete();
    first_pend = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);
    burst(32'h0000_0020, 0, 1'b0, 0, '0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      a  = $urandom;
      wa = ((a / 4) % WORDS) / 8 * 8 + $urandom_range(0, 7);
      burst(a, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), wa, $urandom,
            1'($urandom_range(0, 1)));
    end

    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", sbq.size(), 32'd0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
